// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU writeback stage.
//   dest_t     : result destination, encodings shared with the decoder
//   wb_state_t : writeback FSM state
package alu_writeback_pkg;

    localparam int DEST_W = 2;

    typedef enum logic [DEST_W-1:0] {
        DEST_NONE = 2'd0,
        DEST_ACC  = 2'd1,
        DEST_REG  = 2'd2,
        DEST_MEM  = 2'd3
    } dest_t;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_MEM_WAIT = 1'b1
    } wb_state_t;

    // Stores are the only destination that stalls the stage.
    function automatic logic is_store(dest_t d);
        return d == DEST_MEM;
    endfunction

endpackage

// File: rtl/alu_writeback_reg_file.sv
// General register file for the writeback stage.
//   clk, rst_n        : clock, synchronous active-low reset (clears all registers)
//   wr_en/wr_idx/wr_data : synchronous write port
//   rd_idx/rd_data    : combinational read port, no write bypass
// Indices at or beyond NUM_REGS drop writes and read as zero.
module reg_file #(
    parameter int DW       = 8,
    parameter int NUM_REGS = 8,
    parameter int RIW      = $clog2(NUM_REGS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [RIW-1:0] wr_idx,
    input  logic [DW-1:0]  wr_data,
    input  logic [RIW-1:0] rd_idx,
    output logic [DW-1:0]  rd_data
);

    localparam logic [RIW:0] LIMIT = (RIW + 1)'(NUM_REGS);

    logic [DW-1:0] regs [NUM_REGS];
    logic          wr_in_range;
    logic          rd_in_range;

    assign wr_in_range = {1'b0, wr_idx} < LIMIT;
    assign rd_in_range = {1'b0, rd_idx} < LIMIT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = regs[rd_idx];
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits one ALU result per handshake to the
// accumulator, the register file or data memory, and holds the
// condition-code flag fed back to the ALU.
//   clk, rst_n                    : clock, synchronous active-low reset
//   in_valid/in_ready             : upstream handshake
//   in_result, in_cc, in_cc_we    : ALU result and flag with flag write enable
//   in_dest, in_reg_idx, in_addr  : destination select, register index, store address
//   acc_o, cc_q                   : accumulator and flag back to the ALU
//   rd_idx/rd_data                : combinational register read
//   mem_wr_en/mem_addr/mem_wdata/mem_ack : store request to data memory
//   retire                        : one-cycle pulse per committed result
//
// state       | meaning
// ------------+-----------------------------------------------------
// WB_IDLE     | accepting results; non-store results commit on transfer
// WB_MEM_WAIT | store presented to memory, upstream stalled until ack
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DW       = 8,
    parameter int NUM_REGS = 8,
    parameter int RIW      = $clog2(NUM_REGS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_result,
    input  logic           in_cc,
    input  logic           in_cc_we,
    input  logic [1:0]     in_dest,
    input  logic [RIW-1:0] in_reg_idx,
    input  logic [DW-1:0]  in_addr,
    output logic [DW-1:0]  acc_o,
    output logic           cc_q,
    input  logic [RIW-1:0] rd_idx,
    output logic [DW-1:0]  rd_data,
    output logic           mem_wr_en,
    output logic [DW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic           mem_ack,
    output logic           retire
);

    wb_state_t state_q;
    wb_state_t state_d;
    dest_t     dest;
    logic      xfer;
    logic      store_done;

    assign dest       = dest_t'(in_dest);
    assign xfer       = in_valid && in_ready;
    assign store_done = (state_q == WB_MEM_WAIT) && mem_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: begin
                if (xfer && is_store(dest)) begin
                    state_d = WB_MEM_WAIT;
                end
            end
            WB_MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // in_ready is a function of state only, so no path from in_valid.
    always_comb begin
        in_ready  = 1'b0;
        mem_wr_en = 1'b0;
        case (state_q)
            WB_IDLE:     in_ready  = 1'b1;
            WB_MEM_WAIT: mem_wr_en = 1'b1;
            default: begin
                in_ready  = 1'b0;
                mem_wr_en = 1'b0;
            end
        endcase
    end

    // Unknown values from the ALU pass through unmasked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_o     <= '0;
            cc_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            retire    <= 1'b0;
        end else begin
            if (xfer && dest == DEST_ACC) begin
                acc_o <= in_result;
            end
            if (xfer && in_cc_we) begin
                cc_q <= in_cc;
            end
            if (xfer && is_store(dest)) begin
                mem_addr  <= in_addr;
                mem_wdata <= in_result;
            end
            retire <= (xfer && !is_store(dest)) || store_done;
        end
    end

    reg_file #(
        .DW       (DW),
        .NUM_REGS (NUM_REGS),
        .RIW      (RIW)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (xfer && dest == DEST_REG),
        .wr_idx  (in_reg_idx),
        .wr_data (in_result),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback. Each committed result pushes its
// expected accumulator/flag onto a queue; a monitor pops and compares on
// every retire pulse.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    localparam int DW       = 8;
    localparam int NUM_REGS = 8;
    localparam int RIW      = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_result;
    logic           in_cc;
    logic           in_cc_we;
    logic [1:0]     in_dest;
    logic [RIW-1:0] in_reg_idx;
    logic [DW-1:0]  in_addr;
    logic [DW-1:0]  acc_o;
    logic           cc_q;
    logic [RIW-1:0] rd_idx;
    logic [DW-1:0]  rd_data;
    logic           mem_wr_en;
    logic [DW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           mem_ack;
    logic           retire;

    typedef struct {
        logic [DW-1:0] acc;
        logic          cc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_writeback #(.DW(DW), .NUM_REGS(NUM_REGS), .RIW(RIW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_cc      (in_cc),
        .in_cc_we   (in_cc_we),
        .in_dest    (in_dest),
        .in_reg_idx (in_reg_idx),
        .in_addr    (in_addr),
        .acc_o      (acc_o),
        .cc_q       (cc_q),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .retire     (retire)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] acc, input logic cc);
        exp_t e;
        e.acc = acc;
        e.cc  = cc;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] dest, input logic [DW-1:0] res,
                         input logic cc, input logic cc_we,
                         input logic [RIW-1:0] idx, input logic [DW-1:0] addr);
        in_valid   = 1'b1;
        in_dest    = dest;
        in_result  = res;
        in_cc      = cc;
        in_cc_we   = cc_we;
        in_reg_idx = idx;
        in_addr    = addr;
    endtask

    // Monitor: every retire pulse consumes exactly one expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && retire === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("retire_unexpected", 32'(retire), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("retire_acc", 32'(acc_o), 32'(e.acc));
                check("retire_cc", 32'(cc_q), 32'(e.cc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_cycles;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_result  = '0;
        in_cc      = 1'b0;
        in_cc_we   = 1'b0;
        in_dest    = DEST_NONE;
        in_reg_idx = '0;
        in_addr    = '0;
        rd_idx     = '0;
        mem_ack    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_acc", 32'(acc_o), 32'h0);
        check("rst_cc", 32'(cc_q), 32'h0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_retire", 32'(retire), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_idx = RIW'(i);
            #1;
            check("rst_reg", 32'(rd_data), 32'h0);
        end
        rst_n = 1'b1;
        tick();

        // ACC 5A with flag write
        drive(DEST_ACC, 8'h5A, 1'b1, 1'b1, 3'd0, 8'h00);
        push(8'h5A, 1'b1);
        tick();
        in_valid = 1'b0;
        check("acc_5a", 32'(acc_o), 32'h5A);
        check("cc_set", 32'(cc_q), 32'h1);
        tick();
        check("retire_one_cycle", 32'(retire), 32'h0);

        // REG idx 3 = C3, read has no bypass
        rd_idx = 3'd3;
        drive(DEST_REG, 8'hC3, 1'b0, 1'b0, 3'd3, 8'h00);
        #1;
        check("reg3_write_cycle", 32'(rd_data), 32'h00);
        push(8'h5A, 1'b1);
        tick();
        in_valid = 1'b0;
        check("reg3_after", 32'(rd_data), 32'hC3);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i != 3) begin
                rd_idx = RIW'(i);
                #1;
                check("reg_other_zero", 32'(rd_data), 32'h0);
            end
        end
        tick();

        // MEM store 10/77, ack after 3 wait cycles; flag cleared by the store
        drive(DEST_MEM, 8'h77, 1'b0, 1'b1, 3'd0, 8'h10);
        push(8'h5A, 1'b0);
        tick();
        in_valid  = 1'b0;
        wr_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_ack = 1'b1;
            #1;
            if (mem_wr_en === 1'b1) wr_cycles++;
            check("store_addr", 32'(mem_addr), 32'h10);
            check("store_data", 32'(mem_wdata), 32'h77);
            check("store_ready_low", 32'(in_ready), 32'h0);
            tick();
        end
        mem_ack = 1'b0;
        check("store_wr_cycles", 32'(wr_cycles), 32'd4);
        check("store_wr_en_drop", 32'(mem_wr_en), 32'h0);
        check("store_ready_back", 32'(in_ready), 32'h1);
        tick();

        // Ack while idle is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_wr_en", 32'(mem_wr_en), 32'h0);
        check("idle_ack_ready", 32'(in_ready), 32'h1);

        // MEM then ACC 01 with in_valid held high
        drive(DEST_MEM, 8'h99, 1'b0, 1'b0, 3'd0, 8'h20);
        push(8'h5A, 1'b0);
        tick();
        drive(DEST_ACC, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00);
        push(8'h01, 1'b0);
        tick();
        check("stall_acc_hold", 32'(acc_o), 32'h5A);
        check("stall_addr", 32'(mem_addr), 32'h20);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("post_ack_acc_hold", 32'(acc_o), 32'h5A);
        check("post_ack_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("acc_01", 32'(acc_o), 32'h01);
        tick();

        // Four back-to-back ACC transfers with flag write disabled
        for (int k = 1; k <= 4; k++) begin
            drive(DEST_ACC, DW'(k * 8'h11), 1'b1, 1'b0, 3'd0, 8'h00);
            push(DW'(k * 8'h11), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        check("b2b_acc", 32'(acc_o), 32'h44);
        check("cc_hold", 32'(cc_q), 32'h0);
        tick();

        // Reset during store wait aborts it
        drive(DEST_MEM, 8'h55, 1'b0, 1'b0, 3'd0, 8'h30);
        tick();
        in_valid = 1'b0;
        check("abort_wr_en_before", 32'(mem_wr_en), 32'h1);
        rst_n = 1'b0;
        tick();
        check("abort_wr_en", 32'(mem_wr_en), 32'h0);
        check("abort_ready", 32'(in_ready), 32'h1);
        check("abort_acc", 32'(acc_o), 32'h0);
        check("abort_retire", 32'(retire), 32'h0);
        rst_n  = 1'b1;
        rd_idx = 3'd3;
        tick();
        check("abort_reg3", 32'(rd_data), 32'h0);
        tick();
        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
